data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_if.sv | 53 +++++
 rtl/data_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for the two-port data memory arbiter.
// Handshake: a requester raises req with we/addr/wdata stable and holds them
// until gnt is seen high in the same cycle; the access completes with a
// one-cycle rvalid pulse on the following cycle, qualifying rdata and err.
// The memory side is a plain command bus: mem_read/mem_write strobe one
// access per cycle, mem_rdata is combinational, writes commit on the next edge.
interface data_mem_arbiter_if #(
    parameter int AW = 32
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [31:0]   a_wdata;
    logic          a_gnt;
    logic          a_rvalid;
    logic [31:0]   a_rdata;
    logic          a_err;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [31:0]   b_wdata;
    logic          b_gnt;
    logic          b_rvalid;
    logic [31:0]   b_rdata;
    logic          b_err;

    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_write;
    logic          mem_read;
    logic [31:0]   mem_rdata;

    // Environment side: requesters plus the memory itself
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata, a_err,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata, b_err,
        input  mem_addr, mem_wdata, mem_write, mem_read,
        output mem_rdata
    );

    // Arbiter side
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata, a_err,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata, b_err,
        output mem_addr, mem_wdata, mem_write, mem_read,
        input  mem_rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// One access per cycle is issued combinationally; its completion (rdata/err)
// is registered and reported one cycle later on the granted port.
module data_mem_arbiter #(
    parameter int DEPTH = 256,
    parameter int AW    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    data_mem_arbiter_if.slave  bus,
    output logic               last_grant   // 0 = A, 1 = B
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    localparam logic [AW:0] DEPTH_LIMIT = (AW + 1)'(DEPTH);

    port_t         last_q;
    port_t         last_next;
    logic          grant_a;
    logic          grant_b;
    logic          any_grant;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic          in_range;
    logic [31:0]   cpl_rdata;

    logic          a_rvalid_q;
    logic [31:0]   a_rdata_q;
    logic          a_err_q;
    logic          b_rvalid_q;
    logic [31:0]   b_rdata_q;
    logic          b_err_q;

    // Round-robin grant and next last_grant; reset blocks all grants
    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        last_next = last_q;
        if (rst_n) begin
            if (bus.a_req && (!bus.b_req || last_q == PORT_B)) begin
                grant_a = 1'b1;
            end else if (bus.b_req) begin
                grant_b = 1'b1;
            end
        end
        if (grant_a) begin
            last_next = PORT_A;
        end else if (grant_b) begin
            last_next = PORT_B;
        end
    end

    // Select the granted port's command and drive the memory bus
    always_comb begin
        sel_we        = 1'b0;
        sel_addr      = '0;
        sel_wdata     = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        if (grant_a) begin
            sel_we    = bus.a_we;
            sel_addr  = bus.a_addr;
            sel_wdata = bus.a_wdata;
        end else if (grant_b) begin
            sel_we    = bus.b_we;
            sel_addr  = bus.b_addr;
            sel_wdata = bus.b_wdata;
        end
        in_range  = ({1'b0, sel_addr} < DEPTH_LIMIT);
        any_grant = grant_a | grant_b;
        if (any_grant) begin
            bus.mem_addr  = sel_addr;
            bus.mem_wdata = sel_wdata;
            bus.mem_write = in_range & sel_we;
            bus.mem_read  = in_range & ~sel_we;
        end
        // Only in-range reads return memory data; writes and errors return 0
        cpl_rdata = (in_range && !sel_we) ? bus.mem_rdata : 32'h0;
    end

    // last_grant register; reset leaves B recorded so A wins first contention
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= PORT_B;
        end else begin
            last_q <= last_next;
        end
    end

    // Completion registers; rdata/err hold while no grant for that port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            a_err_q    <= 1'b0;
            b_rvalid_q <= 1'b0;
            b_rdata_q  <= '0;
            b_err_q    <= 1'b0;
        end else begin
            a_rvalid_q <= grant_a;
            b_rvalid_q <= grant_b;
            if (grant_a) begin
                a_rdata_q <= cpl_rdata;
                a_err_q   <= ~in_range;
            end
            if (grant_b) begin
                b_rdata_q <= cpl_rdata;
                b_err_q   <= ~in_range;
            end
        end
    end

    assign bus.a_gnt    = grant_a;
    assign bus.b_gnt    = grant_b;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.a_err    = a_err_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.b_err    = b_err_q;
    assign last_grant   = last_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed accesses against a behavioural memory,
// expected completions queued at grant time and matched on rvalid.
module tb_data_mem_arbiter;

    localparam int DEPTH = 256;
    localparam int AW    = 32;

    logic clk;
    logic rst_n;
    logic last_grant;
    int   cyc;
    int   checks;
    int   errors;

    // {port (0=A,1=B), err, rdata}
    logic [33:0] exp_q[$];

    logic [31:0] mem [0:DEPTH-1];

    data_mem_arbiter_if #(.AW(AW)) bus ();

    data_mem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .last_grant (last_grant)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: combinational read, write on edge
    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[7:0]] : 32'h0;
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: grant exclusivity every cycle, completions against the queue
    always @(negedge clk) begin
        logic [33:0] item;
        check("gnt_exclusive", {63'h0, bus.a_gnt & bus.b_gnt}, 64'h0);
        if (bus.a_rvalid && bus.b_rvalid) check("rvalid_exclusive", 64'h1, 64'h0);
        if (bus.a_rvalid || bus.b_rvalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 64'h1, 64'h0);
            end else begin
                item = exp_q.pop_front();
                check("cpl_port", {63'h0, bus.b_rvalid}, {63'h0, item[33]});
                check("cpl_err", {63'h0, bus.b_rvalid ? bus.b_err : bus.a_err}, {63'h0, item[32]});
                check("cpl_rdata", {32'h0, bus.b_rvalid ? bus.b_rdata : bus.a_rdata}, {32'h0, item[31:0]});
            end
        end
    end

    task automatic set_port(input bit port, input bit req, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
        end else begin
            bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
        end
    endtask

    // Driver: called just after a rising edge; holds the request until granted
    task automatic issue(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input bit exp_err, output int gcyc);
        bit granted;
        granted = 1'b0;
        gcyc = -1;
        set_port(port, 1'b1, we, addr, wdata);
        for (int i = 0; i < 4 && !granted; i++) begin
            @(negedge clk);
            if (port ? bus.b_gnt : bus.a_gnt) begin
                granted = 1'b1;
                gcyc = cyc;
                exp_q.push_back({port, exp_err, exp_rdata});
                check("mem_write", {63'h0, bus.mem_write}, {63'h0, we & ~exp_err});
                check("mem_read", {63'h0, bus.mem_read}, {63'h0, ~we & ~exp_err});
                if (!exp_err) check("mem_addr", {32'h0, bus.mem_addr}, {32'h0, addr});
            end
        end
        if (!granted) check("grant_timeout", 64'h0, 64'h1);
        @(posedge clk);
        #1;
        set_port(port, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        int ga, gb, gw;
        cyc = 0;
        checks = 0;
        errors = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        mem[1] = 32'd1;
        mem[2] = 32'd1001;
        rst_n = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state, with a request held to show grants are suppressed
        repeat (2) @(posedge clk);
        #1;
        set_port(1'b0, 1'b1, 1'b0, 32'h1, 32'h0);
        @(negedge clk);
        check("rst_a_gnt", {63'h0, bus.a_gnt}, 64'h0);
        check("rst_mem_read", {63'h0, bus.mem_read}, 64'h0);
        check("rst_a_rvalid", {63'h0, bus.a_rvalid}, 64'h0);
        check("rst_b_rvalid", {63'h0, bus.b_rvalid}, 64'h0);
        check("rst_a_rdata", {32'h0, bus.a_rdata}, 64'h0);
        check("rst_b_err", {63'h0, bus.b_err}, 64'h0);
        check("rst_last_grant", {63'h0, last_grant}, 64'h1);
        @(posedge clk);
        #1;
        set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;

        // First contention after reset: A then B, data 1 and 1001
        fork
            issue(1'b0, 1'b0, 32'd1, 32'h0, 32'd1, 1'b0, ga);
            issue(1'b1, 1'b0, 32'd2, 32'h0, 32'd1001, 1'b0, gb);
        join
        check("contend_a_first", 64'(gb - ga), 64'd1);

        // A write then back-to-back read of the same address
        issue(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 32'h0, 1'b0, gw);
        issue(1'b0, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, ga);
        check("wr_rd_consecutive", 64'(ga - gw), 64'd1);

        // Out-of-range write from B
        issue(1'b1, 1'b1, 32'd256, 32'hCAFEF00D, 32'h0, 1'b1, gb);
        @(negedge clk);
        check("oor_mem0_unchanged", {32'h0, mem[0]}, 64'h0);
        @(posedge clk);
        #1;

        // Both ports held for 6 cycles: strict alternation starting with A
        set_port(1'b0, 1'b1, 1'b0, 32'd1, 32'h0);
        set_port(1'b1, 1'b1, 1'b0, 32'd2, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("alt_a_gnt", {63'h0, bus.a_gnt}, {63'h0, (k % 2) == 0});
            check("alt_b_gnt", {63'h0, bus.b_gnt}, {63'h0, (k % 2) == 1});
            if ((k % 2) == 0) exp_q.push_back({1'b0, 1'b0, 32'd1});
            else              exp_q.push_back({1'b1, 1'b0, 32'd1001});
        end
        @(posedge clk);
        #1;
        set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // A write granted, then reset lands before the completing edge
        set_port(1'b0, 1'b1, 1'b1, 32'd7, 32'h12345678);
        @(negedge clk);
        check("pre_rst_a_gnt", {63'h0, bus.a_gnt}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("in_rst_a_gnt", {63'h0, bus.a_gnt}, 64'h0);
        check("in_rst_mem_write", {63'h0, bus.mem_write}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("post_rst_last_grant", {63'h0, last_grant}, 64'h1);
        @(negedge clk);
        check("post_rst_a_rvalid", {63'h0, bus.a_rvalid}, 64'h0);
        check("post_rst_mem7", {32'h0, mem[7]}, 64'h0);
        @(posedge clk);
        #1;
        fork
            issue(1'b0, 1'b0, 32'd1, 32'h0, 32'd1, 1'b0, ga);
            issue(1'b1, 1'b0, 32'd2, 32'h0, 32'd1001, 1'b0, gb);
        join
        check("post_rst_a_first", 64'(gb - ga), 64'd1);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
